// File: rtl/range_binner_nb.sv
// Single-pass threshold binner: scans a 2^A-word source memory, stably partitions
// the words into low/mid/high buffers and exposes per-bin counts plus a masked readback port.
module range_binner_nb #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] lo_th,
  input  logic [N-1:0] hi_th,
  output logic [A-1:0] src_addr,
  input  logic [N-1:0] src_data,
  output logic         busy,
  output logic         done,
  output logic [A:0]   cnt_lo,
  output logic [A:0]   cnt_mid,
  output logic [A:0]   cnt_hi,
  input  logic [1:0]   rd_bin,
  input  logic [A-1:0] rd_addr,
  output logic [N-1:0] rd_data
);

  localparam int D = 1 << A;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] BIN_LO  = 2'd0;
  localparam logic [1:0] BIN_MID = 2'd1;
  localparam logic [1:0] BIN_HI  = 2'd2;

  logic [1:0]   state;
  logic [1:0]   sel;
  logic         scan_we;
  logic [N-1:0] rd_word;

  logic [N-1:0] mem_lo  [D];
  logic [N-1:0] mem_mid [D];
  logic [N-1:0] mem_hi  [D];

  assign busy    = (state == SCAN);
  assign done    = (state == DONE);
  assign scan_we = busy && !clr;

  // Low test wins, so inverted thresholds leave the mid bin empty.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    sel = BIN_MID;
    if (src_data < lo_th)
      sel = BIN_LO;
    else if (src_data > hi_th)
      sel = BIN_HI;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state    <= IDLE;
      src_addr <= '0;
      cnt_lo   <= '0;
      cnt_mid  <= '0;
      cnt_hi   <= '0;
    end else begin
      case (state)
        SCAN: begin
          src_addr <= src_addr + A'(1);
          case (sel)
            BIN_LO:  cnt_lo  <= cnt_lo  + (A+1)'(1);
            BIN_HI:  cnt_hi  <= cnt_hi  + (A+1)'(1);
            default: cnt_mid <= cnt_mid + (A+1)'(1);
          endcase
          if (src_addr == '1)
            state <= DONE;
        end
        IDLE, DONE: begin
          if (start) begin
            state    <= SCAN;
            src_addr <= '0;
            cnt_lo   <= '0;
            cnt_mid  <= '0;
            cnt_hi   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: buffers carry no reset; stale words are hidden by the count mask on readback.
  always_ff @(posedge clk) begin
    if (scan_we) begin
      case (sel)
        BIN_LO:  mem_lo[cnt_lo[A-1:0]]   <= src_data;
        BIN_HI:  mem_hi[cnt_hi[A-1:0]]   <= src_data;
        default: mem_mid[cnt_mid[A-1:0]] <= src_data;
      endcase
    end
  end

  // Readback only exposes slots below the bin's current count.
  always_comb begin
    rd_word = '0;
    case (rd_bin)
      BIN_LO:  if ({1'b0, rd_addr} < cnt_lo)  rd_word = mem_lo[rd_addr];
      BIN_MID: if ({1'b0, rd_addr} < cnt_mid) rd_word = mem_mid[rd_addr];
      BIN_HI:  if ({1'b0, rd_addr} < cnt_hi)  rd_word = mem_hi[rd_addr];
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr)
      rd_data <= '0;
    else
      rd_data <= rd_word;
  end

endmodule
